// File: rtl/spi_ram_master_if.sv
// spi_ram_master_if: host request/response port and SPI pins of spi_ram_master
interface spi_ram_master_if;
  logic req_valid, req_ready, req_rd;
  logic [7:0] req_addr, req_wdata;
  logic rsp_valid;
  logic [7:0] rsp_rdata;
  logic SS_n, MOSI, MISO, busy;
  modport master(input req_valid, req_rd, req_addr, req_wdata, MISO,
                 output req_ready, rsp_valid, rsp_rdata, SS_n, MOSI, busy);
  modport slave(output req_valid, req_rd, req_addr, req_wdata, MISO,
                input req_ready, rsp_valid, rsp_rdata, SS_n, MOSI, busy);
endinterface

// File: rtl/spi_ram_master.sv
// spi_ram_master: two-frame SPI command sequencer for single-byte RAM accesses; SPI_ADDR_SKIP_EN skips repeated address frames
module spi_ram_master #(
  parameter int GAP = 1,
  parameter int RD_LAT = 1
) (
  input logic clk,
  input logic rst_n,
  spi_ram_master_if.master bus
);
  typedef enum logic [2:0] {IDLE, SEL, SHIFT, WAIT, RECV, GAP_S} state_t;
  state_t state;
  logic rd, frame, hit;
  logic [7:0] addr, wdata, sh;
  logic [3:0] cnt;
  logic [15:0] tmr;
  logic [10:0] word;
  assign word = {rd, rd, frame, frame ? (rd ? 8'h00 : wdata) : addr};
  assign bus.busy = ~bus.req_ready;
`ifdef SPI_ADDR_SKIP_EN
  logic [7:0] last_waddr, last_raddr;
  logic wv, rv;
  assign hit = bus.req_rd ? rv && last_raddr == bus.req_addr : wv && last_waddr == bus.req_addr;
  // remember the last accepted address of each access type
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      last_waddr <= '0;
      last_raddr <= '0;
      wv <= 1'b0;
      rv <= 1'b0;
    end else if (bus.req_valid && bus.req_ready) begin
      if (bus.req_rd) begin
        rv <= 1'b1;
        last_raddr <= bus.req_addr;
      end else begin
        wv <= 1'b1;
        last_waddr <= bus.req_addr;
      end
    end
`else
  assign hit = 1'b0;
`endif
  // request sequencing, frame shifting and read capture; outputs registered from the next state
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      rd <= 1'b0;
      frame <= 1'b0;
      addr <= '0;
      wdata <= '0;
      sh <= '0;
      cnt <= '0;
      tmr <= '0;
      bus.SS_n <= 1'b1;
      bus.MOSI <= 1'b0;
      bus.req_ready <= 1'b1;
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= '0;
    end else begin
      bus.rsp_valid <= 1'b0;
      case (state)
        IDLE: if (bus.req_valid) begin
          rd <= bus.req_rd;
          addr <= bus.req_addr;
          wdata <= bus.req_wdata;
          frame <= hit;
          state <= SEL;
          bus.SS_n <= 1'b0;
          bus.req_ready <= 1'b0;
        end
        SEL: begin
          state <= SHIFT;
          bus.MOSI <= word[10];
          cnt <= 4'd10;
        end
        SHIFT: if (cnt == 4'd0) begin
          bus.MOSI <= 1'b0;
          if (rd && frame) begin
            state <= RD_LAT > 0 ? WAIT : RECV;
            tmr <= RD_LAT > 0 ? 16'(RD_LAT - 1) : 16'd7;
          end else begin
            state <= GAP_S;
            bus.SS_n <= 1'b1;
            tmr <= 16'(GAP - 1);
          end
        end else begin
          bus.MOSI <= word[cnt - 4'd1];
          cnt <= cnt - 4'd1;
        end
        WAIT: if (tmr == 16'd0) begin
          state <= RECV;
          tmr <= 16'd7;
        end else tmr <= tmr - 16'd1;
        RECV: begin
          sh <= {sh[6:0], bus.MISO};
          if (tmr == 16'd0) begin
            state <= GAP_S;
            bus.SS_n <= 1'b1;
            tmr <= 16'(GAP - 1);
            bus.rsp_valid <= 1'b1;
            bus.rsp_rdata <= {sh[6:0], bus.MISO};
          end else tmr <= tmr - 16'd1;
        end
        GAP_S: if (tmr != 16'd0) tmr <= tmr - 16'd1;
        else if (frame) begin
          state <= IDLE;
          bus.req_ready <= 1'b1;
        end else begin
          state <= SEL;
          frame <= 1'b1;
          bus.SS_n <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_spi_ram_master.sv
// tb_spi_ram_master: scoreboard bench driving host requests against a behavioural SPI RAM slave
module tb_spi_ram_master;
  localparam int G = 1, L = 1;
  logic clk = 1'b0, rst_n = 1'b0;
  spi_ram_master_if bus();
  spi_ram_master #(.GAP(G), .RD_LAT(L)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.master));
  always #5 clk = ~clk;

  int n_cmp = 0, n_err = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  logic [10:0] exp_frame[$];
  logic [7:0] exp_rsp[$];
  int exp_rsp_at[$], exp_ready[$], acc_rel[$];
  logic [7:0] model[256], ram[256];
  bit wv, rv;
  logic [7:0] lw, lr;

  int rel = 0, idx = 0, hi = 0, rsp_cnt = 0;
  bit acc_next = 0, prev_ready = 1, prev_addr = 0;
  logic [10:0] sr, ef;
  logic [7:0] sa;
  // SPI RAM slave model plus frame, response and handshake monitor
  always @(negedge clk) begin
    if (!rst_n) begin
      idx = 0; hi = 0; acc_next = 0; prev_ready = 1; prev_addr = 0; bus.MISO = 1'b0;
    end else begin
      rel = acc_next ? 1 : rel + 1;
      if (!bus.SS_n) begin
        if (idx == 0 && prev_addr) begin
          check("gap_len", hi, G);
          prev_addr = 0;
        end
        if (idx >= 1 && idx <= 11) sr = {sr[9:0], bus.MOSI};
        bus.MISO = 1'b0;
        if (idx >= 12 + L && idx <= 19 + L && sr[10:8] == 3'b111) bus.MISO = ram[sa][19 + L - idx];
        idx++;
        hi = 0;
      end else begin
        if (idx > 0) begin
          check("frame_pending", exp_frame.size() > 0, 1);
          if (exp_frame.size() > 0) begin
            ef = exp_frame.pop_front();
            check("frame_word", sr, ef);
            check("frame_len", idx, ef[10:8] == 3'b111 ? 20 + L : 12);
          end
          if (sr[10:8] == 3'b000 || sr[10:8] == 3'b110) sa = sr[7:0];
          if (sr[10:8] == 3'b001) ram[sa] = sr[7:0];
          prev_addr = !sr[8];
        end
        idx = 0;
        hi++;
        bus.MISO = 1'b0;
      end
      if (bus.rsp_valid) begin
        rsp_cnt++;
        check("rsp_pending", exp_rsp.size() > 0, 1);
        if (exp_rsp.size() > 0) begin
          check("rsp_data", bus.rsp_rdata, exp_rsp.pop_front());
          check("rsp_cycle", rel, exp_rsp_at.pop_front());
        end
      end
      if (bus.req_ready && !prev_ready) begin
        check("ready_pending", exp_ready.size() > 0, 1);
        if (exp_ready.size() > 0) check("ready_cycle", rel, exp_ready.pop_front());
      end
      prev_ready = bus.req_ready;
      acc_next = bus.req_valid && bus.req_ready;
      if (acc_next) acc_rel.push_back(rel);
    end
  end

  task automatic send(input bit rd, input logic [7:0] a, input logic [7:0] d, input bit hold);
    bit skip;
    int base, n;
`ifdef SPI_ADDR_SKIP_EN
    skip = rd ? (rv && lr == a) : (wv && lw == a);
    if (rd) begin rv = 1; lr = a; end
    else begin wv = 1; lw = a; end
`else
    skip = 0;
`endif
    base = skip ? -(12 + G) : 0;
    if (!skip) exp_frame.push_back({rd, rd, 1'b0, a});
    exp_frame.push_back({rd, rd, 1'b1, rd ? 8'h00 : d});
    if (rd) begin
      exp_rsp.push_back(model[a]);
      exp_rsp_at.push_back(33 + G + L + base);
      exp_ready.push_back(33 + 2 * G + L + base);
    end else begin
      model[a] = d;
      exp_ready.push_back(25 + 2 * G + base);
    end
    bus.req_valid = 1'b1; bus.req_rd = rd; bus.req_addr = a; bus.req_wdata = d;
    n = 0;
    @(negedge clk);
    while (!bus.req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("accept_timeout", n < 100, 1);
    @(posedge clk);
    #1;
    if (!hold) bus.req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_frame.size() > 0 || exp_rsp.size() > 0 || exp_ready.size() > 0 || !bus.req_ready) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", n < 300, 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, saved;
    logic [7:0] addrs[4];
    logic [7:0] d;
    addrs = '{8'h01, 8'h7E, 8'hC3, 8'h5A};
    for (int i = 0; i < 256; i++) begin model[i] = 8'h00; ram[i] = 8'h00; end
    wv = 0; rv = 0;
    bus.req_valid = 1'b0; bus.req_rd = 1'b0; bus.req_addr = 8'h00; bus.req_wdata = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_ss_n", bus.SS_n, 1);
    check("rst_mosi", bus.MOSI, 0);
    check("rst_req_ready", bus.req_ready, 1);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_rsp_rdata", bus.rsp_rdata, 8'h00);
    check("rst_busy", bus.busy, 0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(0, 8'hA5, 8'h3C, 0);
    @(negedge clk);
    check("busy_after_accept", bus.busy, 1);
    check("ready_after_accept", bus.req_ready, 0);
    wait_idle();
    check("ram_a5", ram[8'hA5], 8'h3C);
    send(1, 8'hA5, 8'h00, 0);
    wait_idle();
    send(0, 8'h20, 8'h11, 1);
    send(0, 8'h21, 8'h22, 0);
    wait_idle();
    check("b2b_accept_cycle", acc_rel[$], 25 + 2 * G);
    check("ram_20", ram[8'h20], 8'h11);
    check("ram_21", ram[8'h21], 8'h22);
    send(1, 8'h20, 8'h00, 0);
    send(1, 8'h21, 8'h00, 0);
    wait_idle();
    send(1, 8'h10, 8'h00, 0); wait_idle();
    send(1, 8'h10, 8'h00, 0); wait_idle();
    send(0, 8'h10, 8'h5C, 0); wait_idle();
    send(1, 8'h10, 8'h00, 0); wait_idle();
    for (int i = 0; i < 4; i++) begin
      d = 8'($urandom_range(0, 255));
      send(0, addrs[i], d, 0);
      send(1, addrs[i], 8'h00, 0);
      wait_idle();
    end
    send(1, 8'hA5, 8'h00, 0);
    n = 0;
    while (rel != 17 + G && n < 100) begin
      @(posedge clk);
      n++;
    end
    check("abort_reach_timeout", n < 100, 1);
    #2;
    check("ss_low_before_abort", bus.SS_n, 0);
    rst_n = 1'b0;
    #1;
    check("ss_async_on_reset", bus.SS_n, 1);
    check("mosi_on_reset", bus.MOSI, 0);
    exp_frame.delete(); exp_rsp.delete(); exp_rsp_at.delete(); exp_ready.delete();
    wv = 0; rv = 0;
    saved = rsp_cnt;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("no_rsp_after_abort", rsp_cnt, saved);
    @(posedge clk);
    #1;
    send(1, 8'hA5, 8'h00, 0);
    wait_idle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
